// File: rtl/memory_stage.sv
// Memory stage of the pipelined Y86-64 core: M pipeline register, 1 KiB data memory
// with combinational 8-byte reads and clocked writes, and the W pipeline register.
module memory_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic        M_bubble,
  input  logic        W_stall,
  output logic [3:0]  M_icode,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] M_valE,
  output logic        M_cnd,
  output logic [3:0]  m_stat,
  output logic [63:0] m_valM,
  output logic [3:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM
);

  localparam logic [3:0]  STAT_AOK  = 4'd1;
  localparam logic [3:0]  STAT_ADR  = 4'd3;
  localparam logic [3:0]  ICODE_NOP = 4'h1;
  localparam logic [3:0]  REG_NONE  = 4'hF;
  localparam logic [63:0] ADDR_MAX  = 64'd1016;

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  logic [3:0]  mStat_q, mStat_d;
  logic [3:0]  mIcode_q, mIcode_d;
  logic        mCnd_q, mCnd_d;
  logic [63:0] mValE_q, mValE_d;
  logic [63:0] mValA_q, mValA_d;
  logic [3:0]  mDstE_q, mDstE_d;
  logic [3:0]  mDstM_q, mDstM_d;

  logic [3:0]  wStat_q, wStat_d;
  logic [3:0]  wIcode_q, wIcode_d;
  logic [63:0] wValE_q, wValE_d;
  logic [63:0] wValM_q, wValM_d;
  logic [3:0]  wDstE_q, wDstE_d;
  logic [3:0]  wDstM_q, wDstM_d;

  logic [7:0]  mem [0:1023];
  logic [63:0] memAddr;
  logic [9:0]  memIdx;
  logic        memRead;
  logic        memWrite;
  logic        dmemError;
  logic        memWe;
  logic [63:0] rdData;

  always_comb begin
    mStat_d  = e_stat;
    mIcode_d = e_icode;
    mCnd_d   = e_cnd;
    mValE_d  = e_valE;
    mValA_d  = e_valA;
    mDstE_d  = e_dstE;
    mDstM_d  = e_dstM;
    if (M_bubble) begin
      mStat_d  = STAT_AOK;
      mIcode_d = ICODE_NOP;
      mCnd_d   = 1'b0;
      mValE_d  = 64'd0;
      mValA_d  = 64'd0;
      mDstE_d  = REG_NONE;
      mDstM_d  = REG_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mStat_q  <= STAT_AOK;
      mIcode_q <= ICODE_NOP;
      mCnd_q   <= 1'b0;
      mValE_q  <= 64'd0;
      mValA_q  <= 64'd0;
      mDstE_q  <= REG_NONE;
      mDstM_q  <= REG_NONE;
    end else begin
      mStat_q  <= mStat_d;
      mIcode_q <= mIcode_d;
      mCnd_q   <= mCnd_d;
      mValE_q  <= mValE_d;
      mValA_q  <= mValA_d;
      mDstE_q  <= mDstE_d;
      mDstM_q  <= mDstM_d;
    end
  end

  // Stack ops (ret/popq) address through valA; everything else uses the ALU result.
  always_comb begin
    memAddr  = 64'd0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    case (mIcode_q)
      I_RMMOVQ, I_CALL, I_PUSHQ: begin
        memAddr  = mValE_q;
        memWrite = 1'b1;
      end
      I_MRMOVQ: begin
        memAddr = mValE_q;
        memRead = 1'b1;
      end
      I_RET, I_POPQ: begin
        memAddr = mValA_q;
        memRead = 1'b1;
      end
      default: begin
        memAddr  = 64'd0;
        memRead  = 1'b0;
        memWrite = 1'b0;
      end
    endcase
  end

  assign dmemError = (memRead || memWrite) && (memAddr > ADDR_MAX);
  assign memIdx    = memAddr[9:0];

  always_comb begin
    rdData = 64'd0;
    if (memRead && !dmemError) begin
      for (int i = 0; i < 8; i++) begin
        rdData[8*i +: 8] = mem[memIdx + 10'(i)];
      end
    end
  end

  assign memWe = memWrite && !dmemError && (mStat_q == STAT_AOK) && !reset;

  // Memory has no reset; the read above sees pre-edge contents, giving old-data semantics.
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int i = 0; i < 8; i++) begin
        mem[memIdx + 10'(i)] <= mValA_q[8*i +: 8];
      end
    end
  end

  assign m_stat = dmemError ? STAT_ADR : mStat_q;
  assign m_valM = rdData;

  always_comb begin
    wStat_d  = m_stat;
    wIcode_d = mIcode_q;
    wValE_d  = mValE_q;
    wValM_d  = m_valM;
    wDstE_d  = mDstE_q;
    wDstM_d  = mDstM_q;
    if (W_stall) begin
      wStat_d  = wStat_q;
      wIcode_d = wIcode_q;
      wValE_d  = wValE_q;
      wValM_d  = wValM_q;
      wDstE_d  = wDstE_q;
      wDstM_d  = wDstM_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wStat_q  <= STAT_AOK;
      wIcode_q <= ICODE_NOP;
      wValE_q  <= 64'd0;
      wValM_q  <= 64'd0;
      wDstE_q  <= REG_NONE;
      wDstM_q  <= REG_NONE;
    end else begin
      wStat_q  <= wStat_d;
      wIcode_q <= wIcode_d;
      wValE_q  <= wValE_d;
      wValM_q  <= wValM_d;
      wDstE_q  <= wDstE_d;
      wDstM_q  <= wDstM_d;
    end
  end

  assign M_icode = mIcode_q;
  assign M_dstE  = mDstE_q;
  assign M_dstM  = mDstM_q;
  assign M_valE  = mValE_q;
  assign M_cnd   = mCnd_q;

  assign W_stat  = wStat_q;
  assign W_icode = wIcode_q;
  assign W_dstE  = wDstE_q;
  assign W_dstM  = wDstM_q;
  assign W_valE  = wValE_q;
  assign W_valM  = wValM_q;

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 e_stat, e_icode  input  4 each  execute-stage status and instruction code.
REQ-004 e_cnd  input  1  execute-stage condition result.
REQ-005 e_valE, e_valA  input  64 each  ALU result and pass-through operand.
REQ-006 e_dstE, e_dstM  input  4 each  destination register IDs; 4'hF = none.
REQ-007 M_bubble  input  1  load NOP into M register instead of e_* values.
REQ-008 W_stall  input  1  hold W register contents.
REQ-009 M_icode, M_dstE, M_dstM  output  4 each  M register fields, for forwarding and hazard logic.
REQ-010 M_valE  output  64  M register field, for forwarding.
REQ-011 M_cnd  output  1  M register field, for mispredict detection.
REQ-012 m_stat  output  4  combinational memory-stage status.
REQ-013 m_valM  output  64  combinational read data.
REQ-014 W_stat, W_icode, W_dstE, W_dstM  output  4 each  W register fields.
REQ-015 W_valE, W_valM  output  64 each  W register fields.

Function
REQ-016 Status codes SHALL be AOK=1, HLT=2, ADR=3, INS=4.
REQ-017 The M register SHALL load e_stat, e_icode, e_cnd, e_valE, e_valA, e_dstE and e_dstM on every rising edge when reset=0 and M_bubble=0.
REQ-018 When M_bubble=1 and reset=0, the M register SHALL load the bubble: stat=1, icode=4'h1, cnd=0, valE=0, valA=0, dstE=4'hF, dstM=4'hF.
REQ-019 Data memory SHALL be 1024 bytes, byte-addressed, with 8-byte little-endian accesses.
REQ-020 Memory address SHALL be M_valE for icode 4, 5, 8 and A; it SHALL be M_valA for icode 9 and B.
REQ-021 A read SHALL occur for icode 5, 9 and B.
REQ-022 A write of M_valA SHALL occur for icode 4, 8 and A.
REQ-023 For any other icode there SHALL be no access, and m_valM SHALL be 0.
REQ-024 dmem_error SHALL be asserted when an access occurs and the 64-bit address is greater than 1016 (unsigned); the full 64-bit address is compared, with no truncation.
REQ-025 m_stat SHALL be 3 (ADR) when dmem_error=1, and M_stat otherwise.
REQ-026 Reads SHALL be combinational, with m_valM valid in the same cycle.
REQ-027 m_valM SHALL be 0 when dmem_error=1.
REQ-028 A write SHALL commit at the rising edge only when M_stat=1, dmem_error=0 and reset=0; otherwise memory SHALL be unchanged.
REQ-029 Read-during-write to the same bytes SHALL return the old data; the new data is visible from the next cycle.
REQ-030 The W register SHALL load m_stat, M_icode, M_valE, m_valM, M_dstE and M_dstM on each rising edge when W_stall=0 and reset=0, and SHALL hold when W_stall=1.
REQ-031 Latency: e_* to M_* is 1 cycle; M_* to W_* is 1 cycle.
REQ-032 M_bubble and W_stall SHALL act independently; both asserted means M takes the bubble and W holds.

Reset
REQ-033 When reset=1 at a rising edge, the M register SHALL take the bubble values of REQ-018, overriding M_bubble.
REQ-034 When reset=1 at a rising edge, the W register SHALL take stat=1, icode=4'h1, valE=0, valM=0, dstE=4'hF, dstM=4'hF, overriding W_stall.
REQ-035 Memory contents SHALL NOT be cleared by reset.
REQ-036 Writes SHALL be suppressed during any cycle in which reset=1, including a reset that arrives mid-sequence.
REQ-037 After reset, m_stat=1 and m_valM=0 until a non-bubble instruction enters M.

Verification
REQ-038 Scenario: rmmovq (icode 4), valE=0x10, valA=0x1122334455667788 -> next cycle, mrmovq (icode 5), valE=0x10 -> m_valM=0x1122334455667788 and byte 0x10 = 0x88.
REQ-039 Scenario: mrmovq with valE=0x3F9 -> m_stat=3, m_valM=0, W_stat=3 one cycle later; valE=0x3F8 -> m_stat=1.
REQ-040 Scenario: pushq (icode A), valE=0x100 -> write at 0x100; popq (icode B), valA=0x100 -> read returns the pushed value; call (icode 8) and ret (icode 9) addressed the same way.
REQ-041 Scenario: rmmovq with M_stat=2 (HLT) -> memory unchanged, m_stat=2.
REQ-042 Scenario: M_bubble=1 with a valid rmmovq on e_* -> M_icode=1, M_dstE=F, no write; W_stall=1 for 2 cycles -> W_* constant.
REQ-043 Scenario: reset pulsed while a write instruction is in M -> no write, all M_*/W_* at reset values next cycle, previously written data still readable.
